// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution stream feeder.
package conv_pkg;

    // Sequencing states of the feeder
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Load-port RAM selection
    localparam logic SEL_IMAGE  = 1'b0;
    localparam logic SEL_FILTER = 1'b1;

    // Address width able to index 'depth' words (at least one bit)
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/conv_feeder_ram.sv
// Single-port RAM: synchronous write, one-cycle registered read.
// Contents are deliberately not reset so that loaded data survives a reset.
module conv_feeder_ram
    import conv_pkg::*;
#(
    parameter int depth    = 121,
    parameter int bitwidth = 8
) (
    input  logic                         clock,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [addr_bits(depth)-1:0]  addr,
    input  logic [bitwidth-1:0]          wr_data,
    output logic [bitwidth-1:0]          rd_data
);

    logic [bitwidth-1:0] mem_r [depth];
    logic [bitwidth-1:0] rd_data_r;

    // Write the addressed word, or capture it into the read register
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_r <= mem_r[addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/conv_stream_feeder.sv
// Streams a stored image (and the filter weights on the first beats) in
// raster order to the convolution datapath. Pipeline: issue -> RAM read ->
// output register, so a beat issued in cycle t is valid in cycle t+2.
module conv_stream_feeder
    import conv_pkg::*;
#(
    parameter int bitwidth    = 8,
    parameter int filterWidth = 3,
    parameter int imageWidth  = 11,
    localparam int filterSize = filterWidth * filterWidth,
    localparam int numPixels  = imageWidth * imageWidth,
    localparam int addrWidth  = addr_bits(numPixels)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [addrWidth-1:0] wr_addr,
    input  logic [bitwidth-1:0]  wr_data,
    input  logic                 start,
    input  logic                 pause,
    output logic [bitwidth-1:0]  data_out,
    output logic                 isValid_out,
    output logic [bitwidth-1:0]  filter_out,
    output logic                 busy,
    output logic                 done
);

    localparam int filtAddrWidth = addr_bits(filterSize);

    state_e                  state_r;
    logic [addrWidth-1:0]    issue_cnt_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    vld_s1_r;
    logic                    filt_ok_s1_r;
    logic                    is_valid_r;
    logic [bitwidth-1:0]     data_out_r;
    logic [bitwidth-1:0]     filter_out_r;

    logic                    idle_s;
    logic                    issue_s;
    logic                    last_issue_s;
    logic                    in_filter_s;
    logic                    img_we_s;
    logic                    filt_we_s;
    logic                    filt_rd_en_s;
    logic [addrWidth-1:0]    img_addr_s;
    logic [filtAddrWidth-1:0] filt_addr_s;
    logic [bitwidth-1:0]     img_rd_s;
    logic [bitwidth-1:0]     filt_rd_s;

    assign idle_s       = (state_r == IDLE);
    assign issue_s      = (state_r == STREAM) && !pause;
    assign last_issue_s = (issue_cnt_r == addrWidth'(numPixels - 1));
    assign in_filter_s  = ({1'b0, issue_cnt_r} < (addrWidth + 1)'(filterSize));

    // Loads only while idle, and only to addresses that exist in the target RAM
    assign img_we_s  = wr_en && idle_s && (wr_sel == SEL_IMAGE)
                       && ({1'b0, wr_addr} < (addrWidth + 1)'(numPixels));
    assign filt_we_s = wr_en && idle_s && (wr_sel == SEL_FILTER)
                       && ({1'b0, wr_addr} < (addrWidth + 1)'(filterSize));

    // The RAMs are single-port: the load address owns them while idle
    assign img_addr_s   = idle_s ? wr_addr : issue_cnt_r;
    assign filt_addr_s  = idle_s ? wr_addr[filtAddrWidth-1:0]
                                 : issue_cnt_r[filtAddrWidth-1:0];
    assign filt_rd_en_s = issue_s && in_filter_s;

    conv_feeder_ram #(
        .depth    (numPixels),
        .bitwidth (bitwidth)
    ) u_image_ram (
        .clock    (clock),
        .wr_en    (img_we_s),
        .rd_en    (issue_s),
        .addr     (img_addr_s),
        .wr_data  (wr_data),
        .rd_data  (img_rd_s)
    );

    conv_feeder_ram #(
        .depth    (filterSize),
        .bitwidth (bitwidth)
    ) u_filter_ram (
        .clock    (clock),
        .wr_en    (filt_we_s),
        .rd_en    (filt_rd_en_s),
        .addr     (filt_addr_s),
        .wr_data  (wr_data),
        .rd_data  (filt_rd_s)
    );

    // Run sequencing: issue counter, busy and done flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            issue_cnt_r <= {addrWidth{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= STREAM;
                        issue_cnt_r <= {addrWidth{1'b0}};
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                STREAM: begin
                    if (!pause) begin
                        issue_cnt_r <= issue_cnt_r + addrWidth'(1);
                        if (last_issue_s) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stage 1 empty means the final beat now sits on the outputs
                    if (!vld_s1_r) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    issue_cnt_r <= {addrWidth{1'b0}};
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    // Beat pipeline: track RAM-read validity and register the outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_s1_r     <= 1'b0;
            filt_ok_s1_r <= 1'b0;
            is_valid_r   <= 1'b0;
            data_out_r   <= {bitwidth{1'b0}};
            filter_out_r <= {bitwidth{1'b0}};
        end else begin
            vld_s1_r     <= issue_s;
            filt_ok_s1_r <= filt_rd_en_s;
            is_valid_r   <= vld_s1_r;
            if (vld_s1_r) begin
                data_out_r   <= img_rd_s;
                filter_out_r <= filt_ok_s1_r ? filt_rd_s : {bitwidth{1'b0}};
            end
        end
    end

    assign data_out    = data_out_r;
    assign isValid_out = is_valid_r;
    assign filter_out  = filter_out_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed bench for conv_stream_feeder (default parameters: 11x11 image, 3x3 filter).
module tb_conv_stream_feeder;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic       wr_sel;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       pause;
    logic [7:0] data_out;
    logic       isValid_out;
    logic [7:0] filter_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    conv_stream_feeder dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .pause       (pause),
        .data_out    (data_out),
        .isValid_out (isValid_out),
        .filter_out  (filter_out),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 7'(addr);
        wr_data = 8'(data);
        step();
        wr_en   = 1'b0;
    endtask

    // One run: start pulsed in local cycle 0. Expected beat k carries
    // data k and weight k+1 for k < 9. Optional pause window, extra start
    // pulses, a write while busy, and a reset at abort_cyc.
    task automatic run(input int pause_cyc, input int pause_len,
                       input int restart_a, input int restart_b,
                       input int busy_wr_cyc, input int abort_cyc,
                       input int exp_done);
        int k = 0;
        int first = -1;
        int b10 = -1;
        int b11 = -1;
        int last = (abort_cyc >= 0) ? abort_cyc : exp_done;
        for (int c = 0; c <= last; c++) begin
            start   = (c == 0) || (c == restart_a) || (c == restart_b);
            pause   = (pause_cyc >= 0) && (c >= pause_cyc) && (c < pause_cyc + pause_len);
            wr_en   = (c == busy_wr_cyc);
            wr_sel  = 1'b0;
            wr_addr = 7'd5;
            wr_data = 8'hFF;
            reset   = (c == abort_cyc);
            check("busy", 32'(busy), 32'((c >= 1) && (c <= exp_done)));
            check("done", 32'(done), 32'(c == exp_done));
            if (c == abort_cyc) begin
                check("abort_valid", 32'(isValid_out), 32'd1);
                check("abort_beat", 32'(data_out), 32'd50);
            end
            if (isValid_out === 1'b1) begin
                check("data", 32'(data_out), 32'(k));
                check("weight", 32'(filter_out), (k < 9) ? 32'(k + 1) : 32'd0);
                if (first < 0) first = c;
                if (k == 10) b10 = c;
                if (k == 11) b11 = c;
                k++;
            end
            step();
        end
        start = 1'b0;
        pause = 1'b0;
        wr_en = 1'b0;
        reset = 1'b0;
        if (abort_cyc >= 0) begin
            check("rst_valid", 32'(isValid_out), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_data", 32'(data_out), 32'd0);
            check("rst_weight", 32'(filter_out), 32'd0);
        end else begin
            check("first_beat_cycle", 32'(first), 32'd3);
            check("beat_count", 32'(k), 32'd121);
            check("beat10_to_11", 32'(b11 - b10), 32'(1 + pause_len));
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = 7'd0;
        wr_data = 8'd0;
        start   = 1'b0;
        pause   = 1'b0;
        step();
        step();
        check("reset_data", 32'(data_out), 32'd0);
        check("reset_valid", 32'(isValid_out), 32'd0);
        check("reset_weight", 32'(filter_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        step();

        // Load filter 1..9 and image[k] = k
        for (int i = 0; i < 9; i++) write_word(1'b1, i, i + 1);
        for (int i = 0; i < 121; i++) write_word(1'b0, i, i);
        step();

        // Plain run: beats in cycles 3..123, done in 124
        run(-1, 0, -1, -1, -1, -1, 124);
        step();

        // Pause for 3 cycles right after beat 10 is issued (cycle 11)
        run(12, 3, -1, -1, -1, -1, 127);
        step();

        // Start pulses during STREAM and in the DONE cycle are ignored; a
        // write to image[5] while busy is dropped. The next run begins one
        // cycle after done.
        run(-1, 0, 50, 124, 60, -1, 124);
        run(-1, 0, -1, -1, -1, -1, 124);
        step();

        // Out-of-range writes must not touch any beat
        write_word(1'b0, 121, 8'hAA);
        write_word(1'b0, 127, 8'hAB);
        write_word(1'b1, 9, 8'hBB);
        write_word(1'b1, 16, 8'hBC);
        step();
        run(-1, 0, -1, -1, -1, -1, 124);
        step();

        // Reset while beat 50 is on the outputs, then a fresh run
        run(-1, 0, -1, -1, -1, 53, 999);
        step();
        run(-1, 0, -1, -1, -1, -1, 124);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
